pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding request at a time, a single
// decode slot, and flush handling that drops stale bus responses.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_new,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_adel,
  input  logic        d_ready
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_next, f_pc_next, f_instr_next;
  logic            f_adel_next, f_valid_next;
  logic            aligned;

  assign aligned    = (pc[1:0] == 2'b00);
  assign pc_plus4   = pc + XLEN'(4);
  assign ireq_addr  = pc;
  // A misaligned PC never reaches the bus; the slot reports the fault instead.
  assign ireq_valid = !reset && (state == S_REQ) && aligned;

  // Next-state, next-PC and slot update.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    f_pc_next    = f_pc;
    f_instr_next = f_instr;
    f_adel_next  = f_adel;
    case (state)
      S_REQ: begin
        if (flush) begin
          pc_next    = pc_new;
          state_next = (aligned && ireq_addr_ok) ? S_DROP : S_REQ;
        end else if (!aligned) begin
          state_next   = S_HOLD;
          f_pc_next    = pc;
          f_instr_next = '0;
          f_adel_next  = 1'b1;
        end else if (ireq_addr_ok) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_next    = pc_new;
          state_next = iresp_data_ok ? S_REQ : S_DROP;
        end else if (iresp_data_ok) begin
          state_next   = S_HOLD;
          f_pc_next    = pc;
          f_instr_next = iresp_data;
          f_adel_next  = 1'b0;
        end
      end
      S_HOLD: begin
        // Flush wins over d_ready: the slot is discarded, not accepted.
        if (flush || d_ready) begin
          pc_next    = pc_new;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (flush) begin
          pc_next = pc_new;
        end
        if (iresp_data_ok) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
    f_valid_next = (state_next == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      f_valid <= 1'b0;
      f_pc    <= '0;
      f_instr <= '0;
      f_adel  <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      f_valid <= f_valid_next;
      f_pc    <= f_pc_next;
      f_instr <= f_instr_next;
      f_adel  <= f_adel_next;
    end
  end

endmodule
